set_assoc_cache: RTL and testbench

// - Parametrised N-way set-associative write-back, write-allocate cache; next generation of PhysicalCache.
// - Integrates the tag/valid/dirty/data arrays, the tag compare, a tree pseudo-LRU replacement policy and a miss FSM.
// - Sits between the CPU port (valid/ready request, one-cycle response pulse) and memory (valid/ready request, valid response).
// - Accesses are whole-line (CACHE_LINE_SIZE bits); there are no byte enables.

---
 rtl/set_assoc_cache.sv | 216 +++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with tree PLRU and a miss FSM.
// Optional hit/miss performance counters are built when CACHE_PERF_CNT_EN is defined.
module set_assoc_cache #(
   parameter int ADDRESS_WIDTH   = 32,
   parameter int SETS            = 64,
   parameter int WAYS            = 4,
   parameter int CACHE_LINE_SIZE = 32,
   parameter int TAG_WIDTH       = ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE/8))
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       reqValid_CPU,
   output logic                       reqReady_CPU,
   input  logic [ADDRESS_WIDTH-1:0]   reqAddress_CPU,
   input  logic [CACHE_LINE_SIZE-1:0] reqDataIn_CPU,
   input  logic                       reqWen_CPU,
   output logic                       respValid_CPU,
   output logic [CACHE_LINE_SIZE-1:0] respDataOut_CPU,
   output logic                       respHit_CPU,
   output logic                       reqValid_MEM,
   input  logic                       reqReady_MEM,
   output logic [ADDRESS_WIDTH-1:0]   reqAddress_MEM,
   output logic [CACHE_LINE_SIZE-1:0] reqDataOut_MEM,
   output logic                       reqWen_MEM,
   input  logic                       respValid_MEM,
   input  logic [CACHE_LINE_SIZE-1:0] respDataIn_MEM,
   output logic [31:0]                hitCount_PERF,
   output logic [31:0]                missCount_PERF
);
   localparam int OFF_W = $clog2(CACHE_LINE_SIZE/8);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);

   localparam logic [2:0] IDLE        = 3'd0;
   localparam logic [2:0] LOOKUP      = 3'd1;
   localparam logic [2:0] WRITEBACK   = 3'd2;
   localparam logic [2:0] REFILL_REQ  = 3'd3;
   localparam logic [2:0] REFILL_WAIT = 3'd4;
   localparam logic [2:0] RESPOND     = 3'd5;

   logic [2:0]                       state;
   logic [ADDRESS_WIDTH-1:OFF_W]     lineQ;
   logic [CACHE_LINE_SIZE-1:0]       dataQ;
   logic                             wenQ;
   logic [WAY_W-1:0]                 victimQ;
   logic [TAG_WIDTH-1:0]             wbTagQ;
   logic [CACHE_LINE_SIZE-1:0]       wbDataQ;

   logic [TAG_WIDTH-1:0]             tagArr  [SETS][WAYS];
   logic [CACHE_LINE_SIZE-1:0]       dataArr [SETS][WAYS];
   logic [SETS-1:0][WAYS-1:0]        validArr;
   logic [SETS-1:0][WAYS-1:0]        dirtyArr;
   logic [SETS-1:0][WAYS-2:0]        plruArr;

   logic [IDX_W-1:0]                 setIdx;
   logic [TAG_WIDTH-1:0]             reqTag;
   logic                             hit;
   logic [WAY_W-1:0]                 hitWay;
   logic                             invFound;
   logic [WAY_W-1:0]                 invWay;
   logic [WAY_W-1:0]                 victim;
   logic                             unusedOffset;

   assign unusedOffset = ^reqAddress_CPU[OFF_W-1:0];
   assign setIdx = lineQ[OFF_W +: IDX_W];
   assign reqTag = lineQ[ADDRESS_WIDTH-1 -: TAG_WIDTH];

   // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 1 sends the victim right.
   function automatic logic [WAY_W-1:0] plruVictim(input logic [WAYS-2:0] t);
      int n;
      n = 0;
      for (int l = 0; l < WAY_W; l++) n = 2*n + 1 + int'(t[n]);
      return WAY_W'(n - (WAYS-1));
   endfunction

   function automatic logic [WAYS-2:0] plruUpdate(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
      logic [WAYS-2:0] r;
      logic            dir;
      int              n;
      r = t;
      n = 0;
      for (int l = 0; l < WAY_W; l++) begin
         dir  = w[WAY_W-1-l];
         r[n] = ~dir;
         n    = 2*n + 1 + int'(dir);
      end
      return r;
   endfunction

   function automatic logic [ADDRESS_WIDTH-1:0] lineAddr(input logic [TAG_WIDTH-1:0] t, input logic [IDX_W-1:0] i);
      return ADDRESS_WIDTH'({t, i}) << OFF_W;
   endfunction

   always_comb begin
      hit      = 1'b0;
      hitWay   = '0;
      invFound = 1'b0;
      invWay   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (validArr[setIdx][w] && tagArr[setIdx][w] == reqTag) begin
            hit    = 1'b1;
            hitWay = WAY_W'(w);
         end
      end
      // Descending scan so the lowest-index invalid way wins.
      for (int w = WAYS-1; w >= 0; w--) begin
         if (!validArr[setIdx][w]) begin
            invFound = 1'b1;
            invWay   = WAY_W'(w);
         end
      end
      victim = invFound ? invWay : plruVictim(plruArr[setIdx]);
   end

   assign reqValid_MEM   = (state == WRITEBACK) || (state == REFILL_REQ);
   assign reqWen_MEM     = (state == WRITEBACK);
   assign reqAddress_MEM = (state == WRITEBACK)  ? lineAddr(wbTagQ, setIdx) :
                           (state == REFILL_REQ) ? lineAddr(reqTag, setIdx) : '0;
   assign reqDataOut_MEM = (state == WRITEBACK)  ? wbDataQ : '0;

   always_ff @(posedge clk) begin
      if (state == LOOKUP && hit && wenQ) dataArr[setIdx][hitWay] <= dataQ;
      if (state == REFILL_WAIT && respValid_MEM) begin
         tagArr[setIdx][victimQ]  <= reqTag;
         dataArr[setIdx][victimQ] <= wenQ ? dataQ : respDataIn_MEM;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         reqReady_CPU    <= 1'b0;
         respValid_CPU   <= 1'b0;
         respDataOut_CPU <= '0;
         respHit_CPU     <= 1'b0;
         lineQ           <= '0;
         dataQ           <= '0;
         wenQ            <= 1'b0;
         victimQ         <= '0;
         wbTagQ          <= '0;
         wbDataQ         <= '0;
         validArr        <= '0;
         dirtyArr        <= '0;
         plruArr         <= '0;
      end else begin
         respValid_CPU <= 1'b0;
         case (state)
            IDLE: begin
               if (reqValid_CPU && reqReady_CPU) begin
                  lineQ        <= reqAddress_CPU[ADDRESS_WIDTH-1:OFF_W];
                  dataQ        <= reqDataIn_CPU;
                  wenQ         <= reqWen_CPU;
                  reqReady_CPU <= 1'b0;
                  state        <= LOOKUP;
               end else begin
                  reqReady_CPU <= 1'b1;
               end
            end
            LOOKUP: begin
               respHit_CPU <= hit;
               if (hit) begin
                  if (wenQ) begin
                     dirtyArr[setIdx][hitWay] <= 1'b1;
                     respDataOut_CPU          <= dataQ;
                  end else begin
                     respDataOut_CPU          <= dataArr[setIdx][hitWay];
                  end
                  plruArr[setIdx] <= plruUpdate(plruArr[setIdx], hitWay);
                  respValid_CPU   <= 1'b1;
                  state           <= RESPOND;
               end else begin
                  victimQ <= victim;
                  wbTagQ  <= tagArr[setIdx][victim];
                  wbDataQ <= dataArr[setIdx][victim];
                  state   <= (validArr[setIdx][victim] && dirtyArr[setIdx][victim]) ? WRITEBACK : REFILL_REQ;
               end
            end
            WRITEBACK:  if (reqReady_MEM) state <= REFILL_REQ;
            REFILL_REQ: if (reqReady_MEM) state <= REFILL_WAIT;
            REFILL_WAIT: begin
               if (respValid_MEM) begin
                  validArr[setIdx][victimQ] <= 1'b1;
                  dirtyArr[setIdx][victimQ] <= wenQ;
                  plruArr[setIdx]           <= plruUpdate(plruArr[setIdx], victimQ);
                  respDataOut_CPU           <= wenQ ? dataQ : respDataIn_MEM;
                  respValid_CPU             <= 1'b1;
                  state                     <= RESPOND;
               end
            end
            RESPOND: begin
               reqReady_CPU <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CACHE_PERF_CNT_EN
   logic [31:0] hitCnt, missCnt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hitCnt  <= '0;
         missCnt <= '0;
      end else if (state == LOOKUP) begin
         if (hit && hitCnt != 32'hFFFF_FFFF)    hitCnt  <= hitCnt + 32'd1;
         if (!hit && missCnt != 32'hFFFF_FFFF)  missCnt <= missCnt + 32'd1;
      end
   end
   assign hitCount_PERF  = hitCnt;
   assign missCount_PERF = missCnt;
`else
   assign hitCount_PERF  = '0;
   assign missCount_PERF = '0;
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: CPU responses and memory requests are checked
// against queues filled by the directed stimulus.
module tb_set_assoc_cache;
   localparam int AW = 16;
   localparam int LW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          reqValid_CPU = 1'b0;
   logic          reqReady_CPU;
   logic [AW-1:0] reqAddress_CPU = '0;
   logic [LW-1:0] reqDataIn_CPU = '0;
   logic          reqWen_CPU = 1'b0;
   logic          respValid_CPU;
   logic [LW-1:0] respDataOut_CPU;
   logic          respHit_CPU;
   logic          reqValid_MEM;
   logic          reqReady_MEM = 1'b0;
   logic [AW-1:0] reqAddress_MEM;
   logic [LW-1:0] reqDataOut_MEM;
   logic          reqWen_MEM;
   logic          respValid_MEM = 1'b0;
   logic [LW-1:0] respDataIn_MEM = '0;
   logic [31:0]   hitCount_PERF;
   logic [31:0]   missCount_PERF;

   set_assoc_cache #(.ADDRESS_WIDTH(AW), .SETS(4), .WAYS(2), .CACHE_LINE_SIZE(LW)) dut (
      .clk(clk), .rst(rst),
      .reqValid_CPU(reqValid_CPU), .reqReady_CPU(reqReady_CPU), .reqAddress_CPU(reqAddress_CPU),
      .reqDataIn_CPU(reqDataIn_CPU), .reqWen_CPU(reqWen_CPU),
      .respValid_CPU(respValid_CPU), .respDataOut_CPU(respDataOut_CPU), .respHit_CPU(respHit_CPU),
      .reqValid_MEM(reqValid_MEM), .reqReady_MEM(reqReady_MEM), .reqAddress_MEM(reqAddress_MEM),
      .reqDataOut_MEM(reqDataOut_MEM), .reqWen_MEM(reqWen_MEM),
      .respValid_MEM(respValid_MEM), .respDataIn_MEM(respDataIn_MEM),
      .hitCount_PERF(hitCount_PERF), .missCount_PERF(missCount_PERF));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [LW-1:0] data; logic hit; bit chkLat; } cpuExp_t;
   typedef struct { logic wen; logic [AW-1:0] addr; logic [LW-1:0] data; } memExp_t;
   cpuExp_t cpuQ[$];
   memExp_t memQ[$];

   int compared = 0, mismatched = 0;
   int acceptCyc = 0, respCnt = 0, memHsCnt = 0;
   int stallCfg = 0, strayReqs = 0;
   bit noResp = 1'b0;

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // CPU response monitor
   always @(negedge clk) begin
      cpuExp_t e;
      if (rst && respValid_CPU) begin
         if (cpuQ.size() == 0) check("unexpected cpu resp", 1, 0);
         else begin
            e = cpuQ.pop_front();
            check("resp data", respDataOut_CPU, e.data);
            check("resp hit", respHit_CPU, e.hit);
            // Negedge after the RESPOND edge; the following edge is the second after acceptance.
            if (e.chkLat) check("hit latency", cyc + 1 - acceptCyc, 2);
         end
         respCnt++;
      end
   end

   // Memory model: optional stall per request, refill answered two cycles after the handshake.
   initial begin
      bit            inReq;
      int            cnt, pend, strayDone;
      logic [48:0]   snap;
      logic [LW-1:0] pendData;
      memExp_t       e;
      inReq = 0; cnt = 0; pend = 0; strayDone = 0; snap = '0; pendData = '0;
      forever begin
         @(negedge clk);
         respValid_MEM = 1'b0;
         if (!rst) begin
            inReq = 0; pend = 0; reqReady_MEM = 1'b0;
         end else begin
            if (strayReqs != strayDone) begin
               strayDone      = strayReqs;
               respValid_MEM  = 1'b1;
               respDataIn_MEM = 32'hBADBAD00;
            end
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  respValid_MEM  = 1'b1;
                  respDataIn_MEM = pendData;
               end
            end
            if (reqValid_MEM) begin
               if (!inReq) begin
                  inReq = 1; cnt = stallCfg;
                  snap  = {reqWen_MEM, reqAddress_MEM, reqDataOut_MEM};
               end else begin
                  check("mem req held", {reqWen_MEM, reqAddress_MEM, reqDataOut_MEM}, snap);
               end
               if (cnt > 0) begin
                  reqReady_MEM = 1'b0;
                  cnt--;
               end else begin
                  reqReady_MEM = 1'b1;
                  inReq = 0;
                  memHsCnt++;
                  if (memQ.size() == 0) check("unexpected mem req", 1, 0);
                  else begin
                     e = memQ.pop_front();
                     check("mem wen", reqWen_MEM, e.wen);
                     check("mem addr", reqAddress_MEM, e.addr);
                     if (e.wen) check("mem wb data", reqDataOut_MEM, e.data);
                     else if (!noResp) begin pend = 2; pendData = e.data; end
                  end
               end
            end else begin
               reqReady_MEM = 1'b0;
               inReq = 0;
            end
         end
      end
   end

   task automatic memPush(logic wen, logic [AW-1:0] addr, logic [LW-1:0] data);
      memExp_t e;
      e.wen = wen; e.addr = addr; e.data = data;
      memQ.push_back(e);
   endtask

   task automatic issue(logic [AW-1:0] addr, logic wen, logic [LW-1:0] wdata);
      int t;
      @(negedge clk);
      reqAddress_CPU = addr; reqWen_CPU = wen; reqDataIn_CPU = wdata; reqValid_CPU = 1'b1;
      t = 0;
      while (!reqReady_CPU && t < 100) begin @(negedge clk); t++; end
      if (!reqReady_CPU) check("accept timeout", 0, 1);
      acceptCyc = cyc + 1;
      @(negedge clk);
      reqValid_CPU = 1'b0;
   endtask

   task automatic txn(logic [AW-1:0] addr, logic wen, logic [LW-1:0] wdata,
                      logic [LW-1:0] expData, logic expHit, bit chkLat);
      cpuExp_t e;
      int      start, t;
      e.data = expData; e.hit = expHit; e.chkLat = chkLat;
      cpuQ.push_back(e);
      start = respCnt;
      issue(addr, wen, wdata);
      t = 0;
      while (respCnt == start && t < 200) begin @(negedge clk); t++; end
      if (respCnt == start) check("resp timeout", 0, 1);
   endtask

   task automatic checkAllZero(string nm);
      check({nm, " reqReady_CPU"}, reqReady_CPU, 0);
      check({nm, " respValid_CPU"}, respValid_CPU, 0);
      check({nm, " respDataOut_CPU"}, respDataOut_CPU, 0);
      check({nm, " respHit_CPU"}, respHit_CPU, 0);
      check({nm, " mem outputs"}, {reqValid_MEM, reqWen_MEM, reqAddress_MEM, reqDataOut_MEM}, 0);
      check({nm, " perf counters"}, {hitCount_PERF, missCount_PERF}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int hs0, t, r0;
      #2 checkAllZero("reset");
      repeat (3) @(negedge clk);
      check("ready low in reset", reqReady_CPU, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("ready after reset", reqReady_CPU, 1);

      // cold miss then hit
      memPush(0, 16'h0040, 32'hDEADBEEF);
      txn(16'h0040, 0, 0, 32'hDEADBEEF, 0, 0);
      txn(16'h0040, 0, 0, 32'hDEADBEEF, 1, 1);
`ifdef CACHE_PERF_CNT_EN
      check("hitCount", hitCount_PERF, 1);
      check("missCount", missCount_PERF, 1);
`else
      check("hitCount", hitCount_PERF, 0);
      check("missCount", missCount_PERF, 0);
`endif

      // write hit, then read back
      txn(16'h0040, 1, 32'h12345678, 32'h12345678, 1, 1);
      txn(16'h0040, 0, 0, 32'h12345678, 1, 1);

      // set 0 eviction: clean victim first, then dirty victim under memory stalls
      txn(16'h0040, 1, 32'hA5A50040, 32'hA5A50040, 1, 1);
      memPush(0, 16'h0080, 32'h80808080);
      txn(16'h0080, 0, 0, 32'h80808080, 0, 0);
      txn(16'h0040, 0, 0, 32'hA5A50040, 1, 1);
      memPush(0, 16'h00C0, 32'hC0C0C0C0);
      txn(16'h00C0, 0, 0, 32'hC0C0C0C0, 0, 0);
      check("clean evict drained", memQ.size(), 0);
      stallCfg = 5;
      hs0 = memHsCnt;
      memPush(1, 16'h0040, 32'hA5A50040);
      memPush(0, 16'h0080, 32'h80808081);
      txn(16'h0080, 0, 0, 32'h80808081, 0, 0);
      check("handshake count", memHsCnt - hs0, 2);
      stallCfg = 0;

      // reset while waiting for refill, then a stray memory response
      noResp = 1'b1;
      hs0 = memHsCnt;
      memPush(0, 16'h0100, 32'h11110000);
      issue(16'h0100, 0, 0);
      t = 0;
      while (memHsCnt == hs0 && t < 100) begin @(negedge clk); t++; end
      check("refill req seen", memHsCnt - hs0, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 checkAllZero("mid-refill reset");
      repeat (2) @(negedge clk);
      checkAllZero("held reset");
      rst = 1'b1;
      r0 = respCnt;
      strayReqs++;
      repeat (6) @(negedge clk);
      check("stray resp ignored", respCnt - r0, 0);
      noResp = 1'b0;
      memPush(0, 16'h0100, 32'h22220100);
      txn(16'h0100, 0, 0, 32'h22220100, 0, 0);

      repeat (4) @(negedge clk);
      check("mem queue drained", memQ.size(), 0);
      check("cpu queue drained", cpuQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
